// File: rtl/write_reg_hazard_tracker.sv
// Write-side hazard tracker: decodes the ID-stage destination register, carries it
// through the EX/MEM/WB slots and raises Stall on read-after-write conflicts.
module write_reg_hazard_tracker #(
    parameter int FORWARDING = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [31:0]          Instruction,
    input  logic [4:0]           RegToRead1,
    input  logic [4:0]           RegToRead2,
    input  logic                 Flush,
    output logic                 Stall,
    output logic [4:0]           WriteRegID,
    output logic [4:0]           ExDest,
    output logic [4:0]           MemDest,
    output logic [4:0]           WbDest,
    output logic                 ExIsLoad,
    output logic [CNT_WIDTH-1:0] StallCount
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       is_load;
    logic       ex_hit;
    logic       mem_hit;
    logic       hazard;

    assign op    = Instruction[31:26];
    assign funct = Instruction[5:0];

    always_comb begin
        WriteRegID = '0;
        is_load    = 1'b0;
        if (Instruction != '0) begin
            case (op)
                6'h00: begin
                    case (funct)
                        6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                        6'h00, 6'h02, 6'h2A: WriteRegID = Instruction[15:11];
                        default:             WriteRegID = '0;
                    endcase
                end
                6'h1C: begin
                    if (funct == 6'h02)
                        WriteRegID = Instruction[15:11];
                end
                6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: WriteRegID = Instruction[20:16];
                6'h23, 6'h21, 6'h20: begin
                    WriteRegID = Instruction[20:16];
                    is_load    = 1'b1;
                end
                6'h03:   WriteRegID = 5'd31;
                default: WriteRegID = '0;
            endcase
        end
    end

    // $zero is never a hazard source, so a zero read register never matches.
    assign ex_hit  = ((RegToRead1 != '0) && (RegToRead1 == ExDest)) ||
                     ((RegToRead2 != '0) && (RegToRead2 == ExDest));
    assign mem_hit = ((RegToRead1 != '0) && (RegToRead1 == MemDest)) ||
                     ((RegToRead2 != '0) && (RegToRead2 == MemDest));

    // WB is never checked: the register file writes in the first half-cycle.
    always_comb begin
        hazard = 1'b0;
        if (FORWARDING != 0)
            hazard = ExIsLoad && ex_hit;
        else
            hazard = ex_hit || mem_hit;
    end

    assign Stall = hazard && !Flush;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ExDest     <= '0;
            MemDest    <= '0;
            WbDest     <= '0;
            ExIsLoad   <= 1'b0;
            StallCount <= '0;
        end else begin
            WbDest  <= MemDest;
            MemDest <= ExDest;
            if (Stall || Flush) begin
                ExDest   <= '0;
                ExIsLoad <= 1'b0;
            end else begin
                ExDest   <= WriteRegID;
                ExIsLoad <= is_load;
            end
            if (Stall && (StallCount != '1))
                StallCount <= StallCount + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_write_reg_hazard_tracker.sv
// Directed bench for write_reg_hazard_tracker: decode table plus stall,
// forwarding, flush, reset and counter-saturation sequences.
module tb_write_reg_hazard_tracker;

    logic        Clk;
    logic        Rst;
    logic [31:0] Instruction;
    logic [4:0]  RegToRead1;
    logic [4:0]  RegToRead2;
    logic        Flush;

    logic        s0, s1, s2;
    logic [4:0]  wr0, wr1, wr2;
    logic [4:0]  ex0, ex1, ex2;
    logic [4:0]  mem0, mem1, mem2;
    logic [4:0]  wb0, wb1, wb2;
    logic        ld0, ld1, ld2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    write_reg_hazard_tracker #(.FORWARDING(0), .CNT_WIDTH(16)) dut0 (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .RegToRead1(RegToRead1),
        .RegToRead2(RegToRead2), .Flush(Flush), .Stall(s0), .WriteRegID(wr0),
        .ExDest(ex0), .MemDest(mem0), .WbDest(wb0), .ExIsLoad(ld0), .StallCount(cnt0)
    );

    write_reg_hazard_tracker #(.FORWARDING(1), .CNT_WIDTH(16)) dut1 (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .RegToRead1(RegToRead1),
        .RegToRead2(RegToRead2), .Flush(Flush), .Stall(s1), .WriteRegID(wr1),
        .ExDest(ex1), .MemDest(mem1), .WbDest(wb1), .ExIsLoad(ld1), .StallCount(cnt1)
    );

    write_reg_hazard_tracker #(.FORWARDING(0), .CNT_WIDTH(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .RegToRead1(RegToRead1),
        .RegToRead2(RegToRead2), .Flush(Flush), .Stall(s2), .WriteRegID(wr2),
        .ExDest(ex2), .MemDest(mem2), .WbDest(wb2), .ExIsLoad(ld2), .StallCount(cnt2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  wr;
        logic        ld;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [4:0] r1, input logic [4:0] r2,
                         input logic fl);
        Instruction = ins;
        RegToRead1  = r1;
        RegToRead2  = r2;
        Flush       = fl;
        #1;
    endtask

    task automatic do_reset();
        drive(32'h0, 5'd0, 5'd0, 1'b0);
        Rst = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0]  = '{32'h00000000, 5'd0,  1'b0};
        vecs[1]  = '{32'h012A4020, 5'd8,  1'b0};
        vecs[2]  = '{32'h01095822, 5'd11, 1'b0};
        vecs[3]  = '{32'h03E00008, 5'd0,  1'b0};
        vecs[4]  = '{32'h00031100, 5'd2,  1'b0};
        vecs[5]  = '{32'h00C7282A, 5'd5,  1'b0};
        vecs[6]  = '{32'h71AE6002, 5'd12, 1'b0};
        vecs[7]  = '{32'h71AE6000, 5'd0,  1'b0};
        vecs[8]  = '{32'h20A40001, 5'd4,  1'b0};
        vecs[9]  = '{32'h341400FF, 5'd20, 1'b0};
        vecs[10] = '{32'h39290001, 5'd9,  1'b0};
        vecs[11] = '{32'h8D280000, 5'd8,  1'b1};
        vecs[12] = '{32'h80430004, 5'd3,  1'b1};
        vecs[13] = '{32'h84270000, 5'd7,  1'b1};
        vecs[14] = '{32'h0C000010, 5'd31, 1'b0};
        vecs[15] = '{32'h08000010, 5'd0,  1'b0};
        vecs[16] = '{32'hAD280000, 5'd0,  1'b0};
        vecs[17] = '{32'h11090004, 5'd0,  1'b0};
        vecs[18] = '{32'h20200005, 5'd0,  1'b0};
        vecs[19] = '{32'h00000000, 5'd0,  1'b0};

        Rst = 1'b1;
        drive(32'h0, 5'd0, 5'd0, 1'b0);
        do_reset();

        // Reset state and nop stream
        chk("rst_ex", ex0, 0);
        chk("rst_mem", mem0, 0);
        chk("rst_wb", wb0, 0);
        chk("rst_ld", ld0, 0);
        chk("rst_stall", s0, 0);
        chk("rst_cnt", cnt0, 0);
        tick();
        tick();
        tick();
        chk("nop_ex", ex0, 0);
        chk("nop_wb", wb0, 0);
        chk("nop_stall", s0, 0);
        chk("nop_cnt", cnt0, 0);

        // Decode table: no reads, so nothing stalls and each dest enters EX
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].instr, 5'd0, 5'd0, 1'b0);
            chk($sformatf("dec_wr[%0d]", i), wr0, vecs[i].wr);
            chk($sformatf("dec_stall[%0d]", i), s0, 0);
            tick();
            chk($sformatf("dec_ex[%0d]", i), ex0, vecs[i].wr);
            chk($sformatf("dec_ld[%0d]", i), ld1, vecs[i].ld);
        end

        // FORWARDING=0: add $8 then sub reading $8 -> 2-cycle stall
        do_reset();
        drive(32'h012A4020, 5'd9, 5'd10, 1'b0);
        chk("a_wr", wr0, 8);
        chk("a_nostall", s0, 0);
        tick();
        chk("a_ex8", ex0, 8);
        drive(32'h01095822, 5'd8, 5'd9, 1'b0);
        chk("a_stall1", s0, 1);
        chk("a_fwd_add_nostall1", s1, 0);
        tick();
        chk("a_bubble", ex0, 0);
        chk("a_mem8", mem0, 8);
        chk("a_stall2", s0, 1);
        chk("a_cnt1", cnt0, 1);
        chk("a_fwd_add_nostall2", s1, 0);
        tick();
        chk("a_wb8", wb0, 8);
        chk("a_clear", s0, 0);
        chk("a_cnt2", cnt0, 2);
        chk("a_fwd_add_nostall3", s1, 0);
        tick();
        chk("a_ex11", ex0, 11);
        chk("a_cnt_hold", cnt0, 2);
        chk("a_fwd_cnt", cnt1, 0);

        // FORWARDING=1: lw $8 then add reading $8 -> exactly one stall
        do_reset();
        drive(32'h8D280000, 5'd9, 5'd0, 1'b0);
        tick();
        chk("b_ex8", ex1, 8);
        chk("b_isload", ld1, 1);
        drive(32'h01685020, 5'd11, 5'd8, 1'b0);
        chk("b_stall", s1, 1);
        tick();
        chk("b_bubble", ex1, 0);
        chk("b_ldclr", ld1, 0);
        chk("b_mem8", mem1, 8);
        chk("b_clear", s1, 0);
        chk("b_cnt1", cnt1, 1);
        tick();
        chk("b_ex10", ex1, 10);
        chk("b_cnt_hold", cnt1, 1);

        // jal writes $31; reader of $31 stalls twice without forwarding
        do_reset();
        drive(32'h0C000010, 5'd0, 5'd0, 1'b0);
        chk("c_wr31", wr0, 31);
        tick();
        chk("c_ex31", ex0, 31);
        drive(32'h03E01020, 5'd31, 5'd0, 1'b0);
        chk("c_stall1", s0, 1);
        tick();
        chk("c_stall2", s0, 1);
        tick();
        chk("c_clear", s0, 0);
        chk("c_cnt2", cnt0, 2);

        // sw producer writes nothing; reads of $0 and of sw operands never stall
        do_reset();
        drive(32'hAD280000, 5'd9, 5'd8, 1'b0);
        chk("d_sw_wr", wr0, 0);
        tick();
        chk("d_sw_ex", ex0, 0);
        drive(32'h11090004, 5'd0, 5'd0, 1'b0);
        chk("d_zero_nostall", s0, 0);
        chk("d_beq_wr", wr0, 0);
        tick();
        drive(32'h01095822, 5'd8, 5'd9, 1'b0);
        chk("d_after_beq_nostall", s0, 0);

        // Flush over a matching hazard, then reset mid-stall
        do_reset();
        drive(32'h012A4020, 5'd9, 5'd10, 1'b0);
        tick();
        drive(32'h01095822, 5'd8, 5'd9, 1'b1);
        chk("e_flush_nostall", s0, 0);
        tick();
        chk("e_flush_bubble", ex0, 0);
        chk("e_flush_mem8", mem0, 8);
        chk("e_flush_cnt", cnt0, 0);
        drive(32'h01095822, 5'd8, 5'd9, 1'b0);
        chk("e_mem_stall", s0, 1);
        tick();
        chk("e_cnt1", cnt0, 1);
        drive(32'h01095822, 5'd8, 5'd9, 1'b0);
        chk("e_wb_nostall", s0, 0);
        drive(32'h012A4020, 5'd0, 5'd0, 1'b0);
        tick();
        drive(32'h01095822, 5'd8, 5'd0, 1'b0);
        chk("e_restall", s0, 1);
        Rst = 1'b0;
        #1;
        chk("e_arst_stall", s0, 0);
        chk("e_arst_ex", ex0, 0);
        chk("e_arst_mem", mem0, 0);
        chk("e_arst_wb", wb0, 0);
        chk("e_arst_cnt", cnt0, 0);
        tick();
        Rst = 1'b1;
        #1;

        // CNT_WIDTH=2 saturation over five stall cycles
        do_reset();
        drive(32'h012A4020, 5'd0, 5'd0, 1'b0);
        tick();
        drive(32'h01095822, 5'd8, 5'd0, 1'b0);
        tick();
        chk("f_sat1", cnt2, 1);
        tick();
        chk("f_sat2", cnt2, 2);
        chk("f_sat_clear", s2, 0);
        tick();
        chk("f_ex11", ex2, 11);
        drive(32'h01606020, 5'd11, 5'd0, 1'b0);
        tick();
        chk("f_sat3", cnt2, 3);
        tick();
        chk("f_sat4", cnt2, 3);
        tick();
        chk("f_ex12", ex2, 12);
        drive(32'h01806820, 5'd12, 5'd0, 1'b0);
        chk("f_stall5", s2, 1);
        tick();
        chk("f_sat5", cnt2, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/write_reg_hazard_tracker.md
Name: write_reg_hazard_tracker

Overview:
- Write-side companion to the ID-stage read-register detection.
- Decodes which register each ID-stage instruction writes: rd for R-type/mul, rt for I-type ALU/loads, $31 for jal.
- Tracks those destinations through the EX, MEM and WB pipeline slots and compares them against the ID-stage read registers.
- Drives the pipeline Stall (bubble insertion) and keeps a saturating stall counter for lab performance reporting.

Parameters:
- FORWARDING, 0: 0 = no forwarding paths, so a match in EX or MEM stalls; 1 = forwarding present, so only load-use (EX holds a load) stalls.
- CNT_WIDTH, 16: width of StallCount.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Instruction  input  32  instruction currently in ID.
- RegToRead1  input  5  rs read by the ID instruction; 0 = none.
- RegToRead2  input  5  rt read by the ID instruction; 0 = none.
- Flush  input  1  taken branch/jump; squash the ID instruction.
- Stall  output  1  combinational; hold PC/IF-ID and insert a bubble.
- WriteRegID  output  5  combinational decoded destination of Instruction; 0 = no write.
- ExDest  output  5  registered destination held in the EX slot.
- MemDest  output  5  registered destination held in the MEM slot.
- WbDest  output  5  registered destination held in the WB slot.
- ExIsLoad  output  1  registered; EX slot holds lw/lh/lb.
- StallCount  output  CNT_WIDTH  registered count of stall cycles, saturating.

Behaviour:
- Reset (Rst=0, asynchronous): ExDest, MemDest, WbDest, ExIsLoad and StallCount all go to 0 immediately. Stall then evaluates to 0.
- Decode of WriteRegID (combinational):
  - Instruction==0 (nop) -> 0.
  - op 0x00 with funct 0x20/22/24/25/26/27/00/02/2A -> [15:11]. Any other funct -> 0.
  - op 0x1C with funct 0x02 (mul) -> [15:11].
  - op 0x08/0A/0C/0D/0E (addi/slti/andi/ori/xori) -> [20:16].
  - op 0x23/21/20 (lw/lh/lb) -> [20:16], and the load flag is set.
  - op 0x03 (jal) -> 31.
  - All other opcodes (j, beq, bne, sw, sh, sb, ...) -> 0.
  - A decoded value of 0 is always "no write": $zero is never tracked.
- Hazard match: a read register r matches slot d when r!=0 and r==d.
- Stall, FORWARDING=0: asserted if RegToRead1 or RegToRead2 matches ExDest or MemDest. WB never matches, because of the write-first-half / read-second-half register file.
- Stall, FORWARDING=1: asserted only when ExIsLoad=1 and either read register matches ExDest.
- Flush=1 forces Stall=0, since the ID instruction is being discarded.
- Each rising edge (Rst=1):
  - WbDest<=MemDest and MemDest<=ExDest always advance.
  - If Stall or Flush: ExDest<=0 and ExIsLoad<=0 (bubble).
  - Otherwise: ExDest<=WriteRegID and ExIsLoad<=decoded load flag.
- StallCount increments on every edge with Stall=1. It holds at all-ones and never wraps.
- Stall duration, FORWARDING=0: 2 cycles when the producer is in EX, 1 cycle when it is in MEM. Stall self-clears as the producer moves to WB.
- Stall duration, FORWARDING=1: exactly 1 cycle per load-use.
- Both read registers matching different slots: a single Stall, with the duration set by the youngest (EX) match.
- Flush and a match in the same cycle: the bubble is inserted, Stall=0, and StallCount does not increment.
- Reset asserted mid-stall: the pipeline slots clear and Stall drops in the same cycle, asynchronously.

Test Plan:
- Reset then nop stream (0x00000000): all slot outputs 0, Stall=0, StallCount=0.
- FORWARDING=0, add $8,$9,$10 (0x012A4020) then sub $11,$8,$9 (0x01095822, RegToRead1=8) held in ID: Stall=1 for 2 cycles (ExDest=8, then MemDest=8). Stall=0 once WbDest=8; StallCount=2; ExDest=11 on the following edge.
- FORWARDING=1, lw $8,0($9) (0x8D280000) then add with RegToRead2=8: Stall=1 for exactly 1 cycle, ExIsLoad=1 during it, then ExDest=0 bubble. Same pair with add as producer: Stall never asserts.
- jal (0x0C000010): WriteRegID=31, ExDest=31 next edge. Reader with RegToRead1=31 under FORWARDING=0 stalls 2 cycles. sw/beq producers give WriteRegID=0 and no stall, including for reads of $0.
- Flush=1 during a matching hazard: Stall=0, ExDest=0 next edge, StallCount unchanged. Drop Rst low mid-stall: all slot outputs 0 asynchronously.
- CNT_WIDTH=2, force 5 stall cycles: StallCount reads 1,2,3,3,3 (saturates, no wrap).
